// File: rtl/exc_irq_ctrl_if.sv
// Bundles the decode-stage request signals and the controller's redirect/status outputs.
// The pipeline (or bench) drives through master and the controller attaches as slave.
interface exc_irq_ctrl_if #(
   parameter int NUM_IRQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_IRQ-1:0] irq;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic               bad_op;
   logic [31:0]        id_pc;
   logic               id_valid;
   logic               stall;
   logic               eret;
   logic               redirect;
   logic [31:0]        redirect_pc;
   logic               exc_flush;
   logic               in_handler;
   logic [31:0]        epc;
   logic [IDX_W+1:0]   cause;
   logic [NUM_IRQ-1:0] pending;

   modport master (
      output irq, mask_we, mask_wdata, bad_op, id_pc, id_valid, stall, eret,
      input  redirect, redirect_pc, exc_flush, in_handler, epc, cause, pending
   );

   modport slave (
      input  irq, mask_we, mask_wdata, bad_op, id_pc, id_valid, stall, eret,
      output redirect, redirect_pc, exc_flush, in_handler, epc, cause, pending
   );
endinterface

// File: rtl/exc_irq_ctrl.sv
// Interrupt/exception controller beside ID: edge-detected maskable irqs plus bad-opcode,
// sequenced USER -> TAKE -> HANDLER -> RETURN with registered redirect/flush outputs.
module exc_irq_ctrl #(
   parameter int          NUM_IRQ  = 4,
   parameter logic [31:0] VEC_BASE = 32'h8000_0000,
   parameter int          IDX_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input logic           clk,
   input logic           reset,
   exc_irq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {USER, TAKE, HANDLER, RETURN} state_e;

   state_e             state_q;
   logic               redirect_q;
   logic [31:0]        redirect_pc_q;
   logic               flush_q;
   logic               in_handler_q;
   logic [31:0]        epc_q;
   logic [IDX_W+1:0]   cause_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] irq_prev_q;

   logic               eligible;
   logic [NUM_IRQ-1:0] enabled_pend;
   logic               irq_hit;
   logic [IDX_W-1:0]   irq_idx;
   logic               take_irq;
   logic [NUM_IRQ-1:0] take_clr;

   assign eligible     = bus.id_valid && !bus.stall;
   assign enabled_pend = pending_q & mask_q;

   // Descending scan so the lowest-index enabled pending line wins.
   always_comb begin
      irq_hit = 1'b0;
      irq_idx = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (enabled_pend[k]) begin
            irq_hit = 1'b1;
            irq_idx = IDX_W'(k);
         end
      end
   end

   assign take_irq = (state_q == USER) && eligible && !bus.bad_op && irq_hit;

   always_comb begin
      take_clr = '0;
      if (take_irq) take_clr[irq_idx] = 1'b1;
   end

   // A fresh edge on a line being taken this cycle re-arms it.
   assign pending_d = (pending_q & ~take_clr) | (bus.irq & ~irq_prev_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q  <= '0;
         mask_q     <= '1;
         irq_prev_q <= '0;
      end else begin
         pending_q  <= pending_d;
         irq_prev_q <= bus.irq;
         if (bus.mask_we) mask_q <= bus.mask_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= USER;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flush_q       <= 1'b0;
         in_handler_q  <= 1'b0;
         epc_q         <= '0;
         cause_q       <= '0;
      end else begin
         unique case (state_q)
            USER: begin
               if (eligible && bus.bad_op) begin
                  state_q       <= TAKE;
                  epc_q         <= bus.id_pc;
                  cause_q       <= {1'b1, 1'b0, {IDX_W{1'b0}}};
                  redirect_pc_q <= VEC_BASE + 32'd8;
                  redirect_q    <= 1'b1;
                  flush_q       <= 1'b1;
                  in_handler_q  <= 1'b1;
               end else if (take_irq) begin
                  state_q       <= TAKE;
                  epc_q         <= bus.id_pc;
                  cause_q       <= {1'b0, 1'b0, irq_idx};
                  redirect_pc_q <= VEC_BASE + 32'd4;
                  redirect_q    <= 1'b1;
                  flush_q       <= 1'b1;
                  in_handler_q  <= 1'b1;
               end
            end
            TAKE: begin
               state_q    <= HANDLER;
               redirect_q <= 1'b0;
               flush_q    <= 1'b0;
            end
            HANDLER: begin
               if (eligible && bus.bad_op) begin
                  state_q       <= TAKE;
                  cause_q       <= {1'b1, 1'b1, {IDX_W{1'b0}}};
                  redirect_pc_q <= VEC_BASE;
                  redirect_q    <= 1'b1;
                  flush_q       <= 1'b1;
               end else if (eligible && bus.eret) begin
                  state_q       <= RETURN;
                  redirect_pc_q <= epc_q;
                  redirect_q    <= 1'b1;
                  flush_q       <= 1'b1;
                  in_handler_q  <= 1'b0;
               end
            end
            RETURN: begin
               state_q    <= USER;
               redirect_q <= 1'b0;
               flush_q    <= 1'b0;
            end
            default: state_q <= USER;
         endcase
      end
   end

   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.exc_flush   = flush_q;
   assign bus.in_handler  = in_handler_q;
   assign bus.epc         = epc_q;
   assign bus.cause       = cause_q;
   assign bus.pending     = pending_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Randomised scoreboard bench for exc_irq_ctrl: a rule-level model queues expected
// redirect events, and a negedge monitor pops one whenever the controller redirects.
module tb_exc_irq_ctrl;
   localparam int          N   = 4;
   localparam logic [31:0] VEC = 32'h8000_0000;

   typedef struct {
      int          cyc;
      logic [31:0] rpc;
      logic [31:0] epc;
      logic [3:0]  cause;
      logic        inH;
   } event_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cycleNo  = 0;

   event_t expQ[$];

   logic [N-1:0] mPend, mMask, mPrev;
   logic         mInH, mBusy;
   logic [31:0]  mEpc;
   logic [3:0]   mCause;

   exc_irq_ctrl_if #(.NUM_IRQ(N), .IDX_W(2)) ifc ();

   exc_irq_ctrl #(.NUM_IRQ(N), .VEC_BASE(VEC), .IDX_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
      end
   endtask

   // Monitor: every redirect must match the oldest outstanding expected event.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("flush_eq_redirect", 32'(ifc.exc_flush), 32'(ifc.redirect));
            if (ifc.redirect) begin
               if (expQ.size() == 0) begin
                  chk("unexpected_redirect", 32'(ifc.redirect), 32'd0);
               end else begin
                  event_t e;
                  e = expQ.pop_front();
                  chk("redirect_cycle", 32'(cycleNo), 32'(e.cyc));
                  chk("redirect_pc", ifc.redirect_pc, e.rpc);
                  chk("epc_at_redirect", ifc.epc, e.epc);
                  chk("cause_at_redirect", 32'(ifc.cause), 32'(e.cause));
                  chk("in_handler_at_redirect", 32'(ifc.in_handler), 32'(e.inH));
               end
            end
         end
      end
   end

   task automatic resetModel();
      mPend  = '0;
      mMask  = '1;
      mPrev  = '0;
      mInH   = 1'b0;
      mBusy  = 1'b0;
      mEpc   = '0;
      mCause = '0;
   endtask

   task automatic pushEvent(input logic [31:0] rpc, input logic inH);
      event_t e;
      e.cyc   = cycleNo + 1;
      e.rpc   = rpc;
      e.epc   = mEpc;
      e.cause = mCause;
      e.inH   = inH;
      expQ.push_back(e);
   endtask

   // Rule-level reference: a cycle right after a redirect is a flush cycle and takes nothing.
   task automatic modelStep(input logic [N-1:0] irqV, input logic mw, input logic [N-1:0] md,
                            input logic bo, input logic [31:0] pc, input logic v,
                            input logic st, input logic er);
      logic [N-1:0] rise;
      int           k;
      rise = irqV & ~mPrev;
      if (mBusy) begin
         mBusy = 1'b0;
      end else if (v && !st) begin
         if (bo) begin
            if (!mInH) begin
               mEpc   = pc;
               mCause = 4'b1000;
               pushEvent(VEC + 8, 1'b1);
            end else begin
               mCause = 4'b1100;
               pushEvent(VEC, 1'b1);
            end
            mInH  = 1'b1;
            mBusy = 1'b1;
         end else if (!mInH && ((mPend & mMask) != '0)) begin
            k = -1;
            for (int i = N - 1; i >= 0; i--) if (mPend[i] && mMask[i]) k = i;
            mPend[k] = 1'b0;
            mEpc     = pc;
            mCause   = {2'b00, 2'(k)};
            mInH     = 1'b1;
            mBusy    = 1'b1;
            pushEvent(VEC + 4, 1'b1);
         end else if (mInH && er) begin
            mInH  = 1'b0;
            mBusy = 1'b1;
            pushEvent(mEpc, 1'b0);
         end
      end
      mPend = mPend | rise;
      mPrev = irqV;
      if (mw) mMask = md;
   endtask

   task automatic checkOutput();
      chk("pending", 32'(ifc.pending), 32'(mPend));
      chk("in_handler", 32'(ifc.in_handler), 32'(mInH));
      chk("epc", ifc.epc, mEpc);
      chk("cause", 32'(ifc.cause), 32'(mCause));
   endtask

   task automatic applyStimulus(input logic [N-1:0] irqV, input logic mw, input logic [N-1:0] md,
                                input logic bo, input logic [31:0] pc, input logic v,
                                input logic st, input logic er);
      ifc.irq        = irqV;
      ifc.mask_we    = mw;
      ifc.mask_wdata = md;
      ifc.bad_op     = bo;
      ifc.id_pc      = pc;
      ifc.id_valid   = v;
      ifc.stall      = st;
      ifc.eret       = er;
      modelStep(irqV, mw, md, bo, pc, v, st, er);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      reset          = 1'b1;
      ifc.irq        = '0;
      ifc.mask_we    = 1'b0;
      ifc.mask_wdata = '0;
      ifc.bad_op     = 1'b0;
      ifc.id_pc      = '0;
      ifc.id_valid   = 1'b0;
      ifc.stall      = 1'b0;
      ifc.eret       = 1'b0;
      expQ.delete();
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [N-1:0] irqCur;
      logic [N-1:0] tog;
      logic [N-1:0] newMask;
      logic         mwR;

      doReset();
      chk("reset_redirect", 32'(ifc.redirect), 32'd0);
      chk("reset_redirect_pc", ifc.redirect_pc, 32'd0);
      chk("reset_flush", 32'(ifc.exc_flush), 32'd0);
      chk("reset_in_handler", 32'(ifc.in_handler), 32'd0);
      chk("reset_epc", ifc.epc, 32'd0);
      chk("reset_cause", 32'(ifc.cause), 32'd0);
      chk("reset_pending", 32'(ifc.pending), 32'd0);

      // irq[2] edge: pending one cycle, then vectored take re-executing 0x00400010.
      applyStimulus(4'b0100, 1'b0, '0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0);
      chk("dir_pending_set", 32'(ifc.pending), 32'h4);
      applyStimulus(4'b0100, 1'b0, '0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0);
      chk("dir_redirect", 32'(ifc.redirect), 32'd1);
      chk("dir_redirect_pc", ifc.redirect_pc, 32'h8000_0004);
      chk("dir_epc", ifc.epc, 32'h0040_0010);
      chk("dir_cause", 32'(ifc.cause), 32'h2);
      chk("dir_pending_clr", 32'(ifc.pending), 32'h0);
      applyStimulus(4'b0000, 1'b0, '0, 1'b0, 32'h8000_0004, 1'b1, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, '0, 1'b0, 32'h8000_0008, 1'b1, 1'b0, 1'b1);
      chk("dir_return_pc", ifc.redirect_pc, 32'h0040_0010);
      chk("dir_return_inh", 32'(ifc.in_handler), 32'd0);

      irqCur = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) tog[b] = ($urandom_range(0, 3) == 0);
         irqCur  = irqCur ^ tog;
         mwR     = ($urandom_range(0, 19) == 0);
         newMask = N'($urandom);
         applyStimulus(irqCur, mwR, newMask,
                       ($urandom_range(0, 9) == 0),
                       32'($urandom) & 32'hFFFF_FFFC,
                       ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 5) == 0));
      end
      repeat (3) applyStimulus(irqCur, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Async reset landing in the TAKE cycle must drop the flush at once.
      doReset();
      applyStimulus(4'b0001, 1'b0, '0, 1'b0, 32'h0040_0100, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, '0, 1'b0, 32'h0040_0100, 1'b1, 1'b0, 1'b0);
      chk("pre_reset_redirect", 32'(ifc.redirect), 32'd1);
      reset = 1'b1;
      expQ.delete();
      resetModel();
      #1;
      chk("async_redirect", 32'(ifc.redirect), 32'd0);
      chk("async_flush", 32'(ifc.exc_flush), 32'd0);
      chk("async_in_handler", 32'(ifc.in_handler), 32'd0);
      chk("async_epc", ifc.epc, 32'd0);
      chk("async_pending", 32'(ifc.pending), 32'd0);
      chk("async_redirect_pc", ifc.redirect_pc, 32'd0);
      doReset();
      repeat (3) applyStimulus(4'b0000, 1'b0, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("queue_drained", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
